// File: rtl/io_pkg.sv
// Shared definitions for the front-panel input stage and the 7-segment printer.
// The state encoding is decoded by the printer's state_i input, so it must stay fixed.
package io_pkg;

  localparam logic [1:0] ST_MODE = 2'b00;
  localparam logic [1:0] ST_A    = 2'b01;
  localparam logic [1:0] ST_B    = 2'b10;
  localparam logic [1:0] ST_RES  = 2'b11;

  localparam int MODE_W   = 4;
  localparam int RESULT_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle rise pulse on each accepted 0->1 transition of the debounced level.
// A rise is only reported once the button has been seen released after reset,
// so a button held through reset does not produce a spurious press.
module btn_debounce #(
  parameter int DB_CNT = 200000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT - 1);

  logic [1:0]       sync_q;
  logic             synced;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       fill_q;
  logic             armed_q;

  assign synced = sync_q[1];

  // Bring the asynchronous button into the clk domain through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  // Accept a new level only after the synced input has disagreed with it for DB_CNT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_o <= 1'b0;
      rise_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      if (synced == level_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_o <= synced;
        rise_o  <= synced & armed_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Arm rise reporting once the synchroniser holds real samples and shows the button released.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else if (fill_q != 2'd2) begin
      fill_q <= fill_q + 2'd1;
    end else if (!synced) begin
      armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/input_sequencer.sv
// Front-panel input stage: debounced confirm button steps a four-state sequence
// (mode select, operand A, operand B, result display), latches the switches,
// launches the compute core with a one-cycle start pulse and holds its result.
module input_sequencer
  import io_pkg::*;
#(
  parameter int DB_CNT = 200000,
  parameter int SW_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_confirm_i,
  input  logic [SW_W-1:0]     sw_i,
  input  logic [RESULT_W-1:0] result_i,
  input  logic                result_valid_i,
  output logic [MODE_W-1:0]   mode_o,
  output logic [1:0]          state_o,
  output logic [SW_W-1:0]     a_o,
  output logic [SW_W-1:0]     b_o,
  output logic                start_o,
  output logic [RESULT_W-1:0] result_o
);

  logic btn_level;
  logic btn_rise;
  logic press;

  btn_debounce #(
    .DB_CNT(DB_CNT)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (btn_confirm_i),
    .level_o (btn_level),
    .rise_o  (btn_rise)
  );

  // A rise always coincides with an accepted high level; qualifying with it keeps
  // the FSM immune to a rise pulse that is not backed by a pressed button.
  assign press = btn_rise & btn_level;

  // Sequence FSM plus the operand, start and result registers it controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_o  <= ST_MODE;
      mode_o   <= '0;
      a_o      <= '0;
      b_o      <= '0;
      start_o  <= 1'b0;
      result_o <= '0;
    end else begin
      start_o <= 1'b0;
      case (state_o)
        ST_MODE: begin
          mode_o <= sw_i[MODE_W-1:0];
          if (press) begin
            state_o <= ST_A;
          end
        end
        ST_A: begin
          if (press) begin
            a_o     <= sw_i;
            state_o <= ST_B;
          end
        end
        ST_B: begin
          if (press) begin
            b_o      <= sw_i;
            start_o  <= 1'b1;
            result_o <= '0;
            state_o  <= ST_RES;
          end
        end
        ST_RES: begin
          if (press) begin
            state_o <= ST_MODE;
          end else if (result_valid_i) begin
            result_o <= result_i;
          end
        end
        default: begin
          state_o <= ST_MODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_sequencer.sv
// Self-checking bench for input_sequencer with a short debounce window.
// Expected values come from a behavioural model of the panel sequence kept in
// bench variables: which step the user is on, and what each step latches.
module tb_input_sequencer;

  localparam int DB_CNT = 4;
  localparam int SW_W   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn = 1'b0;
  logic [7:0]  sw = 8'h00;
  logic [31:0] result = 32'h0;
  logic        result_valid = 1'b0;
  logic [3:0]  mode_o;
  logic [1:0]  state_o;
  logic [7:0]  a_o;
  logic [7:0]  b_o;
  logic        start_o;
  logic [31:0] result_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: current step 0..3 (mode, A, B, result) and latched values.
  int          exp_state = 0;
  logic [3:0]  exp_mode = 4'h0;
  logic [7:0]  exp_a = 8'h00;
  logic [7:0]  exp_b = 8'h00;
  logic [31:0] exp_result = 32'h0;

  input_sequencer #(
    .DB_CNT(DB_CNT),
    .SW_W  (SW_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_confirm_i  (btn),
    .sw_i           (sw),
    .result_i       (result),
    .result_valid_i (result_valid),
    .mode_o         (mode_o),
    .state_o        (state_o),
    .a_o            (a_o),
    .b_o            (b_o),
    .start_o        (start_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    exp_state  = 0;
    exp_mode   = 4'h0;
    exp_a      = 8'h00;
    exp_b      = 8'h00;
    exp_result = 32'h0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    btn = 1'b0;
    result_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  // Press the button cleanly with the given switches; the step must advance exactly
  // DB_CNT+3 edges later, once, and the button is then released and allowed to settle.
  task automatic do_press(input logic [7:0] swv, input bit collide, input logic [31:0] rv);
    int prev;
    int hold;
    logic [3:0] mode_exp;
    prev = exp_state;
    sw = swv;
    btn = 1'b1;
    for (int k = 1; k <= DB_CNT + 2; k++) begin
      @(negedge clk);
      mode_exp = (exp_state == 0) ? sw[3:0] : exp_mode;
      tests_run++;
      if (state_o !== exp_state[1:0] || start_o !== 1'b0 || mode_o !== mode_exp) begin
        tests_failed++;
        $display("[TB] FAIL press_wait k=%0d: state=%b start=%b mode=%h, expected state=%b start=0 mode=%h",
                 k, state_o, start_o, mode_o, exp_state[1:0], mode_exp);
      end
      if (k == DB_CNT + 2 && collide) begin
        result = rv;
        result_valid = 1'b1;
      end
    end
    @(negedge clk);
    result_valid = 1'b0;
    case (prev)
      0: begin exp_mode = swv[3:0]; exp_state = 1; end
      1: begin exp_a = swv; exp_state = 2; end
      2: begin exp_b = swv; exp_result = 32'h0; exp_state = 3; end
      default: exp_state = 0;
    endcase
    tests_run++;
    if (state_o !== exp_state[1:0] || start_o !== (prev == 2) || a_o !== exp_a || b_o !== exp_b ||
        result_o !== exp_result || (exp_state != 0 && mode_o !== exp_mode)) begin
      tests_failed++;
      $display("[TB] FAIL press_step from %0d: state=%b start=%b a=%h b=%h res=%h mode=%h, expected state=%b start=%b a=%h b=%h res=%h mode=%h",
               prev, state_o, start_o, a_o, b_o, result_o, mode_o,
               exp_state[1:0], (prev == 2), exp_a, exp_b, exp_result, exp_mode);
    end
    if (exp_state == 0) exp_mode = sw[3:0];
    hold = $urandom_range(2, 6);
    for (int k = 0; k < hold + DB_CNT + 5; k++) begin
      if (k == hold) btn = 1'b0;
      @(negedge clk);
      mode_exp = (exp_state == 0) ? sw[3:0] : exp_mode;
      tests_run++;
      if (state_o !== exp_state[1:0] || start_o !== 1'b0 || mode_o !== mode_exp || result_o !== exp_result) begin
        tests_failed++;
        $display("[TB] FAIL press_settle k=%0d: state=%b start=%b mode=%h res=%h, expected state=%b start=0 mode=%h res=%h",
                 k, state_o, start_o, mode_o, result_o, exp_state[1:0], mode_exp, exp_result);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw = 8'hA7;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    tests_run++;
    if (state_o !== 2'b00 || mode_o !== 4'h0 || a_o !== 8'h00 || b_o !== 8'h00 ||
        start_o !== 1'b0 || result_o !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: state=%b mode=%h a=%h b=%h start=%b res=%h, expected all zero",
               state_o, mode_o, a_o, b_o, start_o, result_o);
    end
    rst = 1'b0;
    sw = 8'h05;
    @(negedge clk);
    tests_run++;
    if (mode_o !== 4'h5 || state_o !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_mode: mode=%h state=%b, expected mode=5 state=00", mode_o, state_o);
    end
    for (int i = 0; i < 4; i++) begin
      sw = 8'($urandom);
      @(negedge clk);
      tests_run++;
      if (mode_o !== sw[3:0] || state_o !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL mode_follow: mode=%h state=%b, expected mode=%h state=00", mode_o, state_o, sw[3:0]);
      end
    end
  endtask

  task automatic test_bounce();
    sw = 8'h09;
    for (int i = 0; i < 12; i++) begin
      btn = ((i / 2) % 2 == 0);
      @(negedge clk);
      tests_run++;
      if (state_o !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL bounce_no_press i=%0d: state=%b, expected 00", i, state_o);
      end
    end
    btn = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      tests_run++;
      if (state_o !== ((k < 7) ? 2'b00 : 2'b01)) begin
        tests_failed++;
        $display("[TB] FAIL bounce_latency k=%0d: state=%b, expected %b", k, state_o, (k < 7) ? 2'b00 : 2'b01);
      end
    end
    exp_state = 1;
    exp_mode = 4'h9;
    sw = 8'hF0;
    for (int k = 0; k < 15; k++) begin
      if (k == 6) btn = 1'b0;
      @(negedge clk);
      tests_run++;
      if (state_o !== 2'b01 || mode_o !== 4'h9) begin
        tests_failed++;
        $display("[TB] FAIL bounce_single_press k=%0d: state=%b mode=%h, expected state=01 mode=9", k, state_o, mode_o);
      end
    end
  endtask

  task automatic test_full_sequence();
    apply_reset();
    do_press(8'h03, 1'b0, 32'h0);
    do_press(8'h1A, 1'b0, 32'h0);
    do_press(8'h2B, 1'b1, $urandom);
    tests_run++;
    if (a_o !== 8'h1A || b_o !== 8'h2B || state_o !== 2'b11 || result_o !== 32'h0 || mode_o !== 4'h3) begin
      tests_failed++;
      $display("[TB] FAIL full_sequence: a=%h b=%h state=%b res=%h mode=%h, expected a=1a b=2b state=11 res=0 mode=3",
               a_o, b_o, state_o, result_o, mode_o);
    end
  endtask

  task automatic test_result_capture();
    logic [31:0] d;
    bit v;
    result = 32'hDEADBEEF;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    tests_run++;
    if (result_o !== 32'hDEADBEEF || state_o !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL result_capture_1: res=%h state=%b, expected res=deadbeef state=11", result_o, state_o);
    end
    result = 32'h1;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    exp_result = 32'h1;
    tests_run++;
    if (result_o !== 32'h1) begin
      tests_failed++;
      $display("[TB] FAIL result_capture_2: res=%h, expected 00000001", result_o);
    end
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      v = 1'($urandom_range(0, 1));
      result = d;
      result_valid = v;
      @(negedge clk);
      if (v) exp_result = d;
      tests_run++;
      if (result_o !== exp_result || state_o !== 2'b11) begin
        tests_failed++;
        $display("[TB] FAIL result_random i=%0d: res=%h state=%b, expected res=%h state=11", i, result_o, state_o, exp_result);
      end
    end
    result_valid = 1'b0;
  endtask

  task automatic test_collision();
    logic [31:0] held;
    held = exp_result;
    do_press(8'($urandom), 1'b1, ~held);
    tests_run++;
    if (state_o !== 2'b00 || result_o !== held) begin
      tests_failed++;
      $display("[TB] FAIL collision: state=%b res=%h, expected state=00 res=%h", state_o, result_o, held);
    end
    result = $urandom;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    tests_run++;
    if (result_o !== held || state_o !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL valid_in_mode: res=%h state=%b, expected res=%h state=00", result_o, state_o, held);
    end
  endtask

  task automatic test_reset_mid_b();
    apply_reset();
    do_press(8'($urandom), 1'b0, 32'h0);
    do_press(8'($urandom), 1'b0, 32'h0);
    sw = 8'($urandom);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests_run++;
      if (state_o !== 2'b00 || start_o !== 1'b0 || a_o !== 8'h00 || b_o !== 8'h00) begin
        tests_failed++;
        $display("[TB] FAIL reset_mid_b k=%0d: state=%b start=%b a=%h b=%h, expected state=00 start=0 a=00 b=00",
                 k, state_o, start_o, a_o, b_o);
      end
    end
    btn = 1'b0;
    repeat (10) @(negedge clk);
    do_press(8'h3C, 1'b0, 32'h0);
    tests_run++;
    if (state_o !== 2'b01 || mode_o !== 4'hC) begin
      tests_failed++;
      $display("[TB] FAIL repress_after_reset: state=%b mode=%h, expected state=01 mode=c", state_o, mode_o);
    end
  endtask

  task automatic test_random_sequences();
    logic [31:0] d;
    for (int i = 0; i < 12; i++) begin
      if (exp_state == 3) begin
        for (int j = 0; j < 3; j++) begin
          d = $urandom;
          result = d;
          result_valid = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (result_valid) exp_result = d;
          result_valid = 1'b0;
          tests_run++;
          if (result_o !== exp_result) begin
            tests_failed++;
            $display("[TB] FAIL random_result i=%0d: res=%h, expected %h", i, result_o, exp_result);
          end
        end
      end
      do_press(8'($urandom), 1'($urandom_range(0, 1)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_full_sequence();
    test_result_capture();
    test_collision();
    test_reset_mid_b();
    test_random_sequences();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
